// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the fetch and load/store requesters, the memory arbiter
// and the single-ported unified memory.
interface rv32_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requesters and memory side.
  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Arbiter/sequencer for the shared instruction/data memory: data has priority,
// a starvation counter forces a fetch grant after STARVE_MAX lost arbitrations.
module rv32_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  rv32_mem_arbiter_if.slave  bus
);

  localparam int             BE_W     = DATA_W / 8;
  localparam logic [2:0]     LAT_C    = 3'(MEM_LAT);
  localparam logic [3:0]     STARVE_C = 4'(STARVE_MAX);

  // S_IDLE | arbitrate and issue the winner to memory
  // S_WAIT | memory access in flight, requests ignored
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                store_q, store_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                fetch_win;
  logic                data_win;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic [BE_W-1:0]     be_mux;

  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (state_q == S_IDLE) begin
      fetch_win = bus.if_req && (!bus.d_req || (starve_cnt_q == STARVE_C));
      data_win  = bus.d_req && !fetch_win;
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    be_mux    = '0;
    if (fetch_win) begin
      addr_mux = bus.if_addr;
      be_mux   = '1;
    end else if (data_win) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
      be_mux    = bus.d_be;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    store_d      = store_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_win || data_win) begin
          state_d   = S_WAIT;
          owner_d   = fetch_win ? OWN_IF : OWN_D;
          store_d   = data_win && bus.d_we;
          lat_cnt_d = LAT_C;
        end
        if (!bus.if_req || fetch_win) begin
          starve_cnt_d = '0;
        end else if (data_win && (starve_cnt_q != STARVE_C)) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        // mem_rdata is valid in the last WAIT cycle; the response is registered.
        if (lat_cnt_q == 3'd1) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end else if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            if (!store_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      store_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      store_q      <= store_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Grants are combinational, so they are gated by rst directly.
  assign bus.if_gnt    = fetch_win && !rst;
  assign bus.d_gnt     = data_win && !rst;
  assign bus.mem_en    = (fetch_win || data_win) && !rst;
  assign bus.mem_we    = data_win && bus.d_we && !rst;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_be    = be_mux;

  assign bus.if_rvalid = if_rvalid_q && !rst;
  assign bus.d_rvalid  = d_rvalid_q && !rst;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: grant vectors from a table, response data and
// latency checked by a scoreboard, hand sequences for multi-cycle corners.
module tb_rv32_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  rv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory models: read data is valid only exactly MEM_LAT cycles after mem_en.
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= bus1.mem_en ? memf(bus1.mem_addr) : (32'hBAD00000 ^ 32'(cyc));
    pipe3[0] <= bus3.mem_en ? memf(bus3.mem_addr) : (32'hBAD10000 ^ 32'(cyc));
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus1.mem_rdata = pipe1;
  assign bus3.mem_rdata = pipe3[2];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for the MEM_LAT=1 instance.
  typedef struct {
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  exp_t        if_q1[$];
  exp_t        d_q1[$];
  logic [31:0] d_model1;
  int          busy_until1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if_q1.delete();
      d_q1.delete();
      d_model1    = '0;
      busy_until1 = 0;
    end else begin
      if (bus1.mem_en || bus1.if_gnt || bus1.d_gnt)
        chk1("grant_outside_idle", 1'(cyc >= busy_until1), 1'b1);
      if (bus1.if_gnt) begin
        if_q1.push_back('{memf(bus1.if_addr), cyc});
        busy_until1 = cyc + 2;
      end
      if (bus1.d_gnt) begin
        if (!bus1.d_we) d_model1 = memf(bus1.d_addr);
        d_q1.push_back('{d_model1, cyc});
        busy_until1 = cyc + 2;
      end
      if (bus1.if_rvalid) begin
        chk1("if_rvalid_expected", 1'(if_q1.size() != 0), 1'b1);
        if (if_q1.size() != 0) begin
          e = if_q1.pop_front();
          chk32("if_rdata", bus1.if_rdata, e.data);
          chk32("if_latency", 32'(cyc - e.gcyc), 32'd2);
        end
      end
      if (bus1.d_rvalid) begin
        chk1("d_rvalid_expected", 1'(d_q1.size() != 0), 1'b1);
        if (d_q1.size() != 0) begin
          e = d_q1.pop_front();
          chk32("d_rdata", bus1.d_rdata, e.data);
          chk32("d_latency", 32'(cyc - e.gcyc), 32'd2);
        end
      end
    end
  end

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((if_q1.size() != 0 || d_q1.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_timeout", 1'(n < lim), 1'b1);
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    logic expf;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                1'b1, 1'b0, 32'h100, 1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF,
                1'b0, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011,
                1'b0, 1'b1, 32'h40, 1'b1, 4'b0011, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h44, 32'h12345678, 4'b1100,
                1'b0, 1'b1, 32'h44, 1'b1, 4'b1100, 32'h12345678};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'b0101,
                1'b0, 1'b1, 32'h300, 1'b0, 4'b0101, 32'h0};
    vecs[5] = '{1'b1, 32'h204, 1'b0, 1'b1, 32'h48, 32'hFFFF0000, 4'hF,
                1'b1, 1'b0, 32'h204, 1'b0, 4'hF, 32'h0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0};

    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_be = '0;

    // Reset with requests pending: nothing may be granted.
    rst = 1'b1;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h100; bus1.d_req = 1'b1; bus1.d_we = 1'b1;
    bus1.d_addr = 32'h2000; bus1.d_wdata = 32'h0; bus1.d_be = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_if_gnt", bus1.if_gnt, 1'b0);
    chk1("rst_d_gnt", bus1.d_gnt, 1'b0);
    chk1("rst_mem_en", bus1.mem_en, 1'b0);
    chk1("rst_mem_we", bus1.mem_we, 1'b0);
    chk1("rst_if_rvalid", bus1.if_rvalid, 1'b0);
    chk1("rst_d_rvalid", bus1.d_rvalid, 1'b0);
    chk32("rst_if_rdata", bus1.if_rdata, 32'h0);
    chk32("rst_d_rdata", bus1.d_rdata, 32'h0);
    bus1.if_req = 1'b0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus1.if_req  = vecs[i].if_req;  bus1.if_addr = vecs[i].if_addr;
      bus1.d_req   = vecs[i].d_req;   bus1.d_we    = vecs[i].d_we;
      bus1.d_addr  = vecs[i].d_addr;  bus1.d_wdata = vecs[i].d_wdata;
      bus1.d_be    = vecs[i].d_be;
      @(negedge clk);
      chk1($sformatf("v%0d_if_gnt", i), bus1.if_gnt, vecs[i].e_if_gnt);
      chk1($sformatf("v%0d_d_gnt", i), bus1.d_gnt, vecs[i].e_d_gnt);
      chk1($sformatf("v%0d_mem_en", i), bus1.mem_en, vecs[i].e_if_gnt | vecs[i].e_d_gnt);
      chk1($sformatf("v%0d_mem_we", i), bus1.mem_we, vecs[i].e_we);
      if (vecs[i].e_if_gnt || vecs[i].e_d_gnt) begin
        chk32($sformatf("v%0d_mem_addr", i), bus1.mem_addr, vecs[i].e_addr);
        chk32($sformatf("v%0d_mem_be", i), 32'(bus1.mem_be), 32'(vecs[i].e_be));
      end
      if (vecs[i].e_d_gnt)
        chk32($sformatf("v%0d_mem_wdata", i), bus1.mem_wdata, vecs[i].e_wdata);
      @(posedge clk); #1;
      bus1.if_req = 1'b0; bus1.d_req = 1'b0;
      drain(10);
    end

    // Simultaneous requests: data first, fetch granted in the d_rvalid cycle.
    @(posedge clk); #1;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h104;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h2000; bus1.d_be = 4'hF;
    @(negedge clk);
    chk1("sim_d_gnt", bus1.d_gnt, 1'b1);
    chk1("sim_if_gnt0", bus1.if_gnt, 1'b0);
    chk32("sim_mem_addr0", bus1.mem_addr, 32'h2000);
    @(posedge clk); #1 bus1.d_req = 1'b0;
    @(negedge clk);
    chk1("sim_wait_mem_en", bus1.mem_en, 1'b0);
    @(negedge clk);
    chk1("sim_d_rvalid", bus1.d_rvalid, 1'b1);
    chk1("sim_if_gnt1", bus1.if_gnt, 1'b1);
    chk32("sim_mem_addr1", bus1.mem_addr, 32'h104);
    @(posedge clk); #1 bus1.if_req = 1'b0;
    drain(10);

    // Starvation: if_req dropped during grant 2 clears the counter.
    sc = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      bus1.if_req = (k != 2); bus1.if_addr = 32'h800 + 32'(k * 4);
      bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h1000 + 32'(k * 4);
      @(negedge clk);
      expf = bus1.if_req && (sc == 4);
      chk1($sformatf("starve%0d_if_gnt", k), bus1.if_gnt, expf);
      chk1($sformatf("starve%0d_d_gnt", k), bus1.d_gnt, !expf);
      if (!bus1.if_req || expf) sc = 0;
      else if (sc < 4) sc++;
      @(posedge clk); #1;
    end
    bus1.if_req = 1'b0; bus1.d_req = 1'b0;
    drain(10);

    // MEM_LAT = 3: load, quiet WAIT despite if_req, then fetch.
    @(posedge clk); #1;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h3000; bus3.d_be = 4'hF;
    @(negedge clk);
    chk1("lat3_d_gnt", bus3.d_gnt, 1'b1);
    chk1("lat3_mem_en", bus3.mem_en, 1'b1);
    chk32("lat3_mem_addr", bus3.mem_addr, 32'h3000);
    @(posedge clk); #1;
    bus3.d_req = 1'b0; bus3.if_req = 1'b1; bus3.if_addr = 32'h600;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk1($sformatf("lat3_w%0d_if_gnt", j), bus3.if_gnt, 1'b0);
      chk1($sformatf("lat3_w%0d_mem_en", j), bus3.mem_en, 1'b0);
      chk1($sformatf("lat3_w%0d_d_rvalid", j), bus3.d_rvalid, 1'b0);
    end
    @(negedge clk);
    chk1("lat3_d_rvalid", bus3.d_rvalid, 1'b1);
    chk32("lat3_d_rdata", bus3.d_rdata, memf(32'h3000));
    chk1("lat3_if_gnt", bus3.if_gnt, 1'b1);
    chk32("lat3_if_mem_addr", bus3.mem_addr, 32'h600);
    @(posedge clk); #1 bus3.if_req = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk1($sformatf("lat3_f%0d_if_rvalid", j), bus3.if_rvalid, 1'b0);
    end
    @(negedge clk);
    chk1("lat3_if_rvalid", bus3.if_rvalid, 1'b1);
    chk32("lat3_if_rdata", bus3.if_rdata, memf(32'h600));

    // Reset one cycle after a fetch grant: abandoned, strobes drop at once.
    @(posedge clk); #1;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h500;
    @(negedge clk);
    chk1("rw_if_gnt", bus1.if_gnt, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk1("rw_if_gnt_rst", bus1.if_gnt, 1'b0);
    chk1("rw_mem_en_rst", bus1.mem_en, 1'b0);
    chk1("rw_if_rvalid_rst", bus1.if_rvalid, 1'b0);
    chk1("rw_d_rvalid_rst", bus1.d_rvalid, 1'b0);
    chk32("rw_if_rdata_rst", bus1.if_rdata, 32'h0);
    chk32("rw_d_rdata_rst", bus1.d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rw_if_gnt_after", bus1.if_gnt, 1'b1);
    chk32("rw_mem_addr_after", bus1.mem_addr, 32'h500);
    @(posedge clk); #1 bus1.if_req = 1'b0;
    drain(10);
    repeat (3) @(negedge clk);

    chk32("sb_empty", 32'(if_q1.size() + d_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
